// File: rtl/mem_pkg.sv
// Shared types for the memory access sequencer: the queued command record and FSM states.
// Widths here are the defaults the top-level parameters must agree with.
package mem_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_ADDR_W = 8;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } seq_state_e;

endpackage

// File: rtl/mem_cmd_fifo.sv
// In-order synchronous FIFO of mem_cmd_t with occupancy count.
// Head entry is visible combinationally on o_pop_data; pop and push may coincide.
module mem_cmd_fifo
  import mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_push,
  input  mem_cmd_t       i_push_data,
  input  logic           i_pop,
  output mem_cmd_t       o_pop_data,
  output logic           o_full,
  output logic           o_empty,
  output logic [PTR_W:0] o_level
);

  mem_cmd_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_level == (PTR_W + 1)'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;

  // NOTE: storage has no reset; pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Command front-end for memory_module: queues read/write requests and replays them one at a
// time onto the single memory port, returning read data on a valid/ready response port.
module mem_access_sequencer
  import mem_pkg::*;
#(
  parameter  int DATA_WIDTH       = MEM_DATA_W,
  parameter  int ADDR_WIDTH       = MEM_ADDR_W,
  parameter  int FIFO_DEPTH       = 4,
  parameter  int MEM_READ_LATENCY = 1,
  localparam int LVL_W            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  busy
);

  localparam int LAT_W = (MEM_READ_LATENCY > 0) ? $clog2(MEM_READ_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_READ_LATENCY);

  seq_state_e            r_state;
  seq_state_e            w_state_next;
  mem_cmd_t              r_cmd;
  mem_cmd_t              w_req_cmd;
  mem_cmd_t              w_fifo_head;
  logic [LAT_W-1:0]      r_lat;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_read_done;

  assign w_req_cmd   = '{we: req_we, addr: req_addr, data: req_data};
  assign w_push      = req_valid && !w_full;
  assign w_pop       = (r_state == IDLE) && !w_empty;
  assign w_read_done = (r_state == READ) && (r_lat == LAT_LAST);

  mem_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_req_cmd),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (fifo_level)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_state_next = w_fifo_head.we ? WRITE : READ;
      WRITE:   w_state_next = IDLE;
      READ:    if (w_read_done) w_state_next = RESP;
      RESP:    if (resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Command, latency counter and response registers. r_cmd only changes on a pop, so the
  // memory address/data lines hold their last value through IDLE and RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd       <= '0;
      r_lat       <= '0;
      r_resp_data <= '0;
    end else begin
      if (w_pop) r_cmd <= w_fifo_head;
      if (r_state == READ) r_lat <= w_read_done ? '0 : r_lat + 1'b1;
      else                 r_lat <= '0;
      if (w_read_done) r_resp_data <= mem_rdata;
    end
  end

  always_comb begin
    req_ready  = !w_full;
    resp_valid = (r_state == RESP);
    resp_data  = r_resp_data;
    mem_we     = (r_state == WRITE);
    mem_addr   = r_cmd.addr;
    mem_wdata  = r_cmd.data;
    busy       = (r_state != IDLE) || !w_empty;
  end

endmodule
